// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch prefetch unit.
package ifu_prefetch_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_INST_W = 32;
    localparam int unsigned PC_INC     = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// ifu_fifo: synchronous FIFO with flush and registered-only output.
// Pushed data becomes visible at the head one cycle later.
// When the FIFO is full, a push is accepted only together with a pop.
module ifu_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Qualify push and pop against the current occupancy.
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        do_pop  = pop && (count_q != '0);
        do_push = push && (!full || do_pop);
    end

    // Storage array; no reset needed because the head is gated when empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a flush discards everything, including a same-cycle push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head is zero whenever the queue is empty.
    always_comb begin
        valid = (count_q != '0);
        head  = valid ? mem[rd_ptr] : '0;
        count = count_q;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction prefetcher with redirect/flush.
// Define IFU_PERF_EN to add the perf_fetched / perf_dropped counters.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter int unsigned        INST_W   = DEF_INST_W,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam int unsigned ENT_W = ADDR_W + INST_W;

    state_t            state;
    state_t            state_next;
    logic              run;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  in_flight;
    logic [SUM_W-1:0]  budget_used;
    logic              req_fire;
    logic              rsp_keep;
    logic              inst_pop;

    logic [ADDR_W-1:0] pcq_head;
    logic              pcq_valid;
    logic [CNT_W-1:0]  pcq_count;
    logic [ENT_W-1:0]  pfq_head;
    logic              pfq_valid;
    logic [CNT_W-1:0]  pfq_count;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= BOOT;
        else        state <= state_next;
    end

    // FSM next state: one idle boot cycle, then run until reset.
    always_comb begin
        state_next = state;
        unique case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // FSM outputs.
    always_comb begin
        run = (state == RUN);
    end

    // Handshake qualification. The pc-queue count plus drop_cnt is the total
    // number of requests still awaiting a response, current and stale streams alike.
    always_comb begin
        in_flight      = drop_cnt + pcq_count;
        budget_used    = SUM_W'(pcq_count) + SUM_W'(drop_cnt) + SUM_W'(pfq_count);
        imem_req_valid = run && !redirect_valid && (budget_used < SUM_W'(DEPTH));
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_cnt == '0) && pcq_valid;
        inst_pop       = pfq_valid && inst_ready && !redirect_valid;
    end

    // Fetch address and stale-response drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= {RESET_PC[ADDR_W-1:2], 2'b00};
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            // A response arriving this cycle retires one in-flight request.
            drop_cnt <= (imem_rsp_valid && (in_flight != '0)) ? in_flight - CNT_W'(1)
                                                               : in_flight;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
            if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
        end
    end

    ifu_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_pc_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_keep),
        .head      (pcq_head),
        .valid     (pcq_valid),
        .count     (pcq_count)
    );

    ifu_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_pf_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data ({pcq_head, imem_rsp_data}),
        .pop       (inst_pop),
        .head      (pfq_head),
        .valid     (pfq_valid),
        .count     (pfq_count)
    );

    // Decode-side view of the prefetch queue head.
    always_comb begin
        inst_valid = pfq_valid;
        inst_pc    = pfq_head[ENT_W-1:INST_W];
        inst_data  = pfq_head[INST_W-1:0];
    end

`ifdef IFU_PERF_EN
    logic rsp_drop;

    // Responses not kept are those discarded as stale or killed by a redirect.
    always_comb begin
        rsp_drop = imem_rsp_valid && !rsp_keep;
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (inst_pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
            if (rsp_drop && (perf_dropped != '1)) perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: in-order memory model with random
// latency and a stream-level reference (expected pc/data per pop, expected
// request address per acceptance, per-stream occupancy bound).
module tb_ifu_prefetch;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
`ifdef IFU_PERF_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_dropped;
`endif

    always #5 clk = ~clk;

    ifu_prefetch #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned gen;
        int unsigned due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] req_log[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc, cur_gen;
    int          delivered, popped;
    int unsigned n_req, n_pop, n_stale;
    int unsigned rdy_pct, lat_min, lat_max;
    logic [31:0] exp_pc, req_exp, prev_addr, first_pop_pc;
    int unsigned first_pop_cyc;
    bit          seen_pop, inv_low_pending, prev_hold;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: drive memory side, sample at negedge, update model after posedge.
    task automatic step();
        bit          redir, fire_req, fire_pop, rsp;
        logic [31:0] raddr;
        mreq_t       e;
        int          occ;
        imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
        rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memf(mem_q[0].addr) : $urandom();
        @(negedge clk);
        redir = redirect_valid;
        if (inv_low_pending) begin
            checks++;
            if (inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL redir_inst_valid_low: got %b want 0", inst_valid);
            end
        end
        if (redir) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_during_redirect: got %b want 0", imem_req_valid);
            end
        end else if (prev_hold) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
                errors++;
                $display("FAIL req_hold: got valid=%b addr=%h want valid=1 addr=%h",
                         imem_req_valid, imem_req_addr, prev_addr);
            end
        end
        fire_req = imem_req_valid && imem_req_ready;
        raddr    = imem_req_addr;
        if (fire_req) begin
            checks++;
            if (raddr !== req_exp) begin
                errors++;
                $display("FAIL req_addr: got %h want %h", raddr, req_exp);
            end
        end
        fire_pop = inst_valid && inst_ready && !redir;
        if (fire_pop) begin
            checks++;
            if (inst_pc !== exp_pc || inst_data !== memf(exp_pc)) begin
                errors++;
                $display("FAIL pop: got pc=%h data=%h want pc=%h data=%h",
                         inst_pc, inst_data, exp_pc, memf(exp_pc));
            end
            if (!seen_pop) begin
                first_pop_pc  = inst_pc;
                first_pop_cyc = cyc;
            end
        end
        prev_hold = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
        @(posedge clk);
        #1;
        if (rsp) begin
            e = mem_q.pop_front();
            if (e.gen == cur_gen && !redir) delivered++;
            else                            n_stale++;
        end
        if (fire_pop) begin
            popped++;
            n_pop++;
            seen_pop = 1'b1;
            exp_pc   = exp_pc + 32'd4;
        end
        if (fire_req) begin
            mem_q.push_back('{raddr, cur_gen, cyc + $urandom_range(lat_min, lat_max)});
            req_log.push_back(raddr);
            n_req++;
            req_exp = raddr + 32'd4;
        end
        if (redir) begin
            cur_gen++;
            delivered = 0;
            popped    = 0;
            exp_pc    = {redirect_pc[31:2], 2'b00};
            req_exp   = exp_pc;
            seen_pop  = 1'b0;
            prev_hold = 1'b0;
        end
        inv_low_pending = redir;
        if (fire_req) begin
            occ = mem_q.size() + delivered - popped;
            checks++;
            if (occ > DEPTH) begin
                errors++;
                $display("FAIL occupancy: got %0d want <= %0d", occ, DEPTH);
            end
        end
        cyc++;
    endtask

    task automatic hold_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        mem_q.delete();
        req_log.delete();
        cyc = 0; cur_gen = 0; delivered = 0; popped = 0;
        n_req = 0; n_pop = 0; n_stale = 0;
        exp_pc = 32'h0; req_exp = 32'h0;
        seen_pop = 1'b0; inv_low_pending = 1'b0; prev_hold = 1'b0;
        rdy_pct = 100; lat_min = 1; lat_max = 1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== 32'h0 ||
            inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL %s: got req_valid=%b inst_valid=%b addr=%h data=%h pc=%h want 0/0/0/0/0",
                     tag, imem_req_valid, inst_valid, imem_req_addr, inst_data, inst_pc);
        end
`ifdef IFU_PERF_EN
        checks++;
        if (perf_fetched !== 32'd0 || perf_dropped !== 32'd0) begin
            errors++;
            $display("FAIL %s_perf: got fetched=%0d dropped=%0d want 0/0", tag, perf_fetched, perf_dropped);
        end
`endif
    endtask

    task automatic test_reset();
        hold_reset();
        check_reset_outputs("reset_values");
        release_reset();
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_no_request: got %b want 0", imem_req_valid);
        end
    endtask

    task automatic test_sequential();
        hold_reset();
        release_reset();
        inst_ready = 1'b1;
        repeat (20) step();
        checks++;
        if (req_log.size() < 4 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 ||
            req_log[2] !== 32'h8 || req_log[3] !== 32'hC) begin
            errors++;
            $display("FAIL seq_addrs: got %0d requests, want 0,4,8,C first", req_log.size());
        end
        checks++;
        if (first_pop_cyc !== 2) begin
            errors++;
            $display("FAIL seq_first_inst_latency: got cycle %0d want 2", first_pop_cyc);
        end
        checks++;
        if (n_pop !== 18) begin
            errors++;
            $display("FAIL seq_throughput: got %0d pops want 18", n_pop);
        end
    endtask

    task automatic test_backpressure();
        hold_reset();
        release_reset();
        repeat (20) step();
        checks++;
        if (n_req !== DEPTH || imem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got req=%0d req_valid=%b inst_valid=%b want %0d/0/1",
                     n_req, imem_req_valid, inst_valid, DEPTH);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        repeat (5) step();
        checks++;
        if (n_req !== DEPTH + 1) begin
            errors++;
            $display("FAIL bp_refill: got %0d requests want %0d", n_req, DEPTH + 1);
        end
        rdy_pct = 0;
        inst_ready = 1'b1;
        repeat (10) step();
        checks++;
        if (n_pop !== n_req || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got pops=%0d inst_valid=%b want pops=%0d inst_valid=0",
                     n_pop, inst_valid, n_req);
        end
    endtask

    task automatic test_redirect_stale();
        hold_reset();
        release_reset();
        lat_min = 6; lat_max = 6;
        inst_ready = 1'b1;
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        req_log.delete();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 40 && !seen_pop; i++) step();
        checks++;
        if (req_log.size() == 0 || req_log[0] !== 32'h100) begin
            errors++;
            $display("FAIL redir_next_addr: got %0d requests want first 00000100", req_log.size());
        end
        checks++;
        if (!seen_pop || first_pop_pc !== 32'h100) begin
            errors++;
            $display("FAIL redir_first_pc: got seen=%b pc=%h want 00000100", seen_pop, first_pop_pc);
        end
`ifdef IFU_PERF_EN
        checks++;
        if (perf_dropped !== 32'd2) begin
            errors++;
            $display("FAIL redir_perf_dropped: got %0d want 2", perf_dropped);
        end
`endif
    endtask

    task automatic test_redirect_collision();
        hold_reset();
        release_reset();
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20 && !(inst_valid && mem_q.size() != 0 && mem_q[0].due <= cyc); i++)
            step();
        checks++;
        if (!(inst_valid && mem_q.size() != 0 && mem_q[0].due <= cyc)) begin
            errors++;
            $display("FAIL collision_setup: got inst_valid=%b pending=%0d want 1/>0",
                     inst_valid, mem_q.size());
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        inst_ready     = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL collision_queue_empty: got inst_valid=%b want 0", inst_valid);
        end
        for (int i = 0; i < 40 && !seen_pop; i++) step();
        checks++;
        if (!seen_pop || first_pop_pc !== 32'h200) begin
            errors++;
            $display("FAIL collision_first_pc: got seen=%b pc=%h want 00000200", seen_pop, first_pop_pc);
        end
    endtask

    task automatic test_wrap();
        hold_reset();
        release_reset();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        req_log.delete();
        repeat (10) step();
        checks++;
        if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got %0d requests want FFFFFFFC then 00000000", req_log.size());
        end
    endtask

    task automatic test_random();
        hold_reset();
        release_reset();
        rdy_pct = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            inst_ready     = ($urandom_range(0, 99) < 60);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_pc    = $urandom();
            step();
        end
        redirect_valid = 1'b0;
        rdy_pct = 0;
        inst_ready = 1'b1;
        repeat (20) step();
        checks++;
        if (inst_valid !== 1'b0 || n_pop < 50) begin
            errors++;
            $display("FAIL random_drain: got inst_valid=%b pops=%0d want 0 and >=50", inst_valid, n_pop);
        end
`ifdef IFU_PERF_EN
        checks++;
        if (perf_fetched !== n_pop || perf_dropped !== n_stale) begin
            errors++;
            $display("FAIL random_perf: got fetched=%0d dropped=%0d want %0d/%0d",
                     perf_fetched, perf_dropped, n_pop, n_stale);
        end
`endif
    endtask

    task automatic test_async_reset();
        hold_reset();
        release_reset();
        rdy_pct = 80; lat_min = 1; lat_max = 3; inst_ready = 1'b1;
        repeat (15) step();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        hold_reset();
        release_reset();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_stale();
        test_redirect_collision();
        test_wrap();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
